// File: rtl/oam_dma_engine.sv
// oam_dma_engine: sprite DMA that halts the CPU and copies one page
// into the OAM data port as read/write pairs, reads on even cycles.
// Ports: clk, reset (sync, high); cpu_addr/cpu_data/cpu_r_w_n snoop
// CPU writes; mem_data_in returns DMA read data; rdy halts the CPU;
// dma_active/dma_addr/dma_data_out/dma_r_w_n drive the bus while the
// DMA owns it; dma_done pulses in the cycle after the final write.
module oam_dma_engine #(
  parameter int                    ADDR_WIDTH    = 16,
  parameter int                    REG_WIDTH     = 8,
  parameter logic [ADDR_WIDTH-1:0] TRIGGER_ADDR  = 16'h4014,
  parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = 16'h2004,
  parameter int                    XFER_LEN      = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [REG_WIDTH-1:0]  cpu_data,
  input  logic                  cpu_r_w_n,
  input  logic [REG_WIDTH-1:0]  mem_data_in,
  output logic                  rdy,
  output logic                  dma_active,
  output logic [ADDR_WIDTH-1:0] dma_addr,
  output logic [REG_WIDTH-1:0]  dma_data_out,
  output logic                  dma_r_w_n,
  output logic                  dma_done
);

  localparam int IDX_W = $clog2(XFER_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [REG_WIDTH-1:0]  r_page;
  logic [REG_WIDTH-1:0]  w_page_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic [REG_WIDTH-1:0]  r_latch;
  logic [REG_WIDTH-1:0]  w_latch_nxt;
  logic                  r_parity;

  logic                  r_rdy;
  logic                  r_active;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [REG_WIDTH-1:0]  r_data;
  logic                  r_r_w_n;
  logic                  r_done;

  logic                  w_rdy_nxt;
  logic                  w_active_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [REG_WIDTH-1:0]  w_data_nxt;
  logic                  w_r_w_n_nxt;
  logic                  w_done_nxt;

  logic                  w_trig;
  logic                  w_last;

  assign w_trig = (cpu_addr == TRIGGER_ADDR) && !cpu_r_w_n;
  assign w_last = (r_idx == IDX_W'(XFER_LEN - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_page_nxt  = r_page;
    w_idx_nxt   = r_idx;
    w_latch_nxt = r_latch;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_trig) begin
          w_state_nxt = S_HALT;
          w_page_nxt  = cpu_data;
        end
      end
      // r_parity=1 means the HALT cycle is odd, so the next one is even
      S_HALT:  w_state_nxt = r_parity ? S_READ : S_ALIGN;
      S_ALIGN: w_state_nxt = S_READ;
      S_READ: begin
        w_latch_nxt = mem_data_in;
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        w_idx_nxt = r_idx + 1'b1;
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_READ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered: decode them from the state being entered.
  always_comb begin
    w_rdy_nxt    = 1'b1;
    w_active_nxt = 1'b0;
    w_addr_nxt   = r_addr;
    w_data_nxt   = r_data;
    w_r_w_n_nxt  = 1'b1;
    unique case (w_state_nxt)
      S_HALT, S_ALIGN: begin
        w_rdy_nxt    = 1'b0;
        w_active_nxt = 1'b1;
      end
      S_READ: begin
        w_rdy_nxt    = 1'b0;
        w_active_nxt = 1'b1;
        w_addr_nxt   = ADDR_WIDTH'({w_page_nxt, w_idx_nxt});
      end
      S_WRITE: begin
        w_rdy_nxt    = 1'b0;
        w_active_nxt = 1'b1;
        w_addr_nxt   = OAM_DATA_ADDR;
        w_data_nxt   = w_latch_nxt;
        w_r_w_n_nxt  = 1'b0;
      end
      default: begin
        w_rdy_nxt    = 1'b1;
        w_active_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_page   <= '0;
      r_idx    <= '0;
      r_latch  <= '0;
      r_parity <= 1'b0;
      r_rdy    <= 1'b1;
      r_active <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_r_w_n  <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_page   <= w_page_nxt;
      r_idx    <= w_idx_nxt;
      r_latch  <= w_latch_nxt;
      r_parity <= ~r_parity;
      r_rdy    <= w_rdy_nxt;
      r_active <= w_active_nxt;
      r_addr   <= w_addr_nxt;
      r_data   <= w_data_nxt;
      r_r_w_n  <= w_r_w_n_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign rdy          = r_rdy;
  assign dma_active   = r_active;
  assign dma_addr     = r_addr;
  assign dma_data_out = r_data;
  assign dma_r_w_n    = r_r_w_n;
  assign dma_done     = r_done;

endmodule

// File: tb/tb_oam_dma_engine.sv
// tb_oam_dma_engine: bus-cycle reference model, vector table and
// directed sequences for the sprite DMA engine.
module tb_oam_dma_engine;

  logic        clk;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_r_w_n;
  logic [7:0]  mem_data_in;
  logic        rdy;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data_out;
  logic        dma_r_w_n;
  logic        dma_done;

  oam_dma_engine dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_addr    (cpu_addr),
    .cpu_data    (cpu_data),
    .cpu_r_w_n   (cpu_r_w_n),
    .mem_data_in (mem_data_in),
    .rdy         (rdy),
    .dma_active  (dma_active),
    .dma_addr    (dma_addr),
    .dma_data_out(dma_data_out),
    .dma_r_w_n   (dma_r_w_n),
    .dma_done    (dma_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] memf(input logic [15:0] a);
    if (a[15:8] == 8'h03) return a[7:0] ^ 8'hA5;
    return (a[7:0] * 8'd7) + a[15:8] + 8'h3C;
  endfunction

  assign mem_data_in = memf(dma_addr);

  int checks = 0;
  int errors = 0;

  // model: transfer accepted at cycle m_t, first READ at m_s
  int          cyc = 0;
  bit          m_have = 0;
  int          m_t = 0;
  int          m_s = 0;
  logic [7:0]  m_page = 8'h00;

  // observations
  int          rdy_low = 0;
  int          done_cnt = 0;
  int          first_read_cyc = -1;
  logic [15:0] prev_addr = 16'h0000;
  logic [7:0]  wq[$];
  logic [15:0] rq[$];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)",
               name, got, got, exp, exp);
    end
  endtask

  task automatic clear_stats();
    rdy_low = 0;
    done_cnt = 0;
    first_read_cyc = -1;
    wq.delete();
    rq.delete();
  endtask

  task automatic compare_model();
    logic        erdy, eact, erw, edone, ca, cd;
    logic [15:0] eaddr;
    logic [7:0]  edata;
    int          off, k;
    erdy = 1; eact = 0; erw = 1; edone = 0; ca = 0; cd = 0;
    eaddr = '0; edata = '0;
    if (m_have) begin
      if (cyc > m_t && cyc < m_s) begin
        erdy = 0; eact = 1;
      end else if (cyc >= m_s && cyc < m_s + 512) begin
        off = cyc - m_s;
        k = off / 2;
        erdy = 0; eact = 1; ca = 1;
        if (off % 2 == 0) begin
          eaddr = {m_page, 8'(k)};
        end else begin
          erw = 0; cd = 1;
          eaddr = 16'h2004;
          edata = memf({m_page, 8'(k)});
        end
      end else if (cyc == m_s + 512) begin
        edone = 1;
      end
    end
    checks++;
    if ({rdy, dma_active, dma_r_w_n, dma_done} !== {erdy, eact, erw, edone}
        || (ca && dma_addr !== eaddr) || (cd && dma_data_out !== edata)) begin
      errors++;
      $display("FAIL model cyc=%0d got rdy=%b act=%b rwn=%b done=%b addr=%h data=%h exp rdy=%b act=%b rwn=%b done=%b addr=%h data=%h",
               cyc, rdy, dma_active, dma_r_w_n, dma_done, dma_addr, dma_data_out,
               erdy, eact, erw, edone, eaddr, edata);
    end
  endtask

  task automatic observe();
    if (!rdy) rdy_low++;
    if (dma_done) done_cnt++;
    if (dma_active && !dma_r_w_n) begin
      wq.push_back(dma_data_out);
      rq.push_back(prev_addr);
      if (first_read_cyc < 0) first_read_cyc = cyc - 1;
    end
    prev_addr = dma_addr;
  endtask

  task automatic tick(input logic [15:0] a, input logic rw, input logic [7:0] d);
    bit idle;
    reset = 0;
    cpu_addr = a;
    cpu_r_w_n = rw;
    cpu_data = d;
    idle = !m_have || (cyc >= m_s + 512);
    if (idle && a == 16'h4014 && !rw) begin
      m_have = 1;
      m_t = cyc;
      m_page = d;
      m_s = cyc + ((cyc % 2 == 0) ? 2 : 3);
    end
    @(posedge clk);
    #1;
    cyc++;
    compare_model();
    observe();
  endtask

  task automatic idle_tick();
    logic [15:0] a;
    logic        rw;
    a = 16'($urandom);
    rw = 1'($urandom);
    if (a == 16'h4014 && !rw) a = 16'h4015;
    tick(a, rw, 8'($urandom));
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) idle_tick();
  endtask

  task automatic wait_done(input int budget);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      idle_tick();
      n++;
    end
    chk("done_seen", done_cnt - d0, 1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      reset = 1;
      cpu_addr = ($urandom % 2 == 1) ? 16'h4014 : 16'($urandom);
      cpu_r_w_n = 1'($urandom);
      cpu_data = 8'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if ({rdy, dma_active, dma_addr, dma_data_out, dma_r_w_n, dma_done}
          !== {1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_vals got rdy=%b act=%b addr=%h data=%h rwn=%b done=%b exp 1 0 0000 00 1 0",
                 rdy, dma_active, dma_addr, dma_data_out, dma_r_w_n, dma_done);
      end
    end
    cyc = 0;
    m_have = 0;
  endtask

  typedef struct {
    logic [15:0] a;
    logic        rw;
    logic [7:0]  d;
    logic        exp_rdy;
  } vec_t;

  vec_t vt[6];

  initial begin
    int tc, n, e;
    vt[0] = '{16'h4014, 1'b1, 8'h02, 1'b1};
    vt[1] = '{16'h4015, 1'b0, 8'h02, 1'b1};
    vt[2] = '{16'h4013, 1'b0, 8'h02, 1'b1};
    vt[3] = '{16'hC014, 1'b0, 8'h02, 1'b1};
    vt[4] = '{16'h4004, 1'b0, 8'h02, 1'b1};
    vt[5] = '{16'h4014, 1'b0, 8'h07, 1'b0};

    reset = 1;
    cpu_addr = '0;
    cpu_data = '0;
    cpu_r_w_n = 1;
    do_reset(3);

    // even-cycle trigger, page 2
    if (cyc % 2 == 1) idle_tick();
    clear_stats();
    tick(16'h4014, 1'b0, 8'h02);
    wait_done(600);
    idle_n(4);
    chk("t2_rdy_low", rdy_low, 513);
    chk("t2_reads", rq.size(), 256);
    chk("t2_first", rq.size() > 0 ? int'(rq[0]) : -1, 16'h0200);
    chk("t2_last", rq.size() > 0 ? int'(rq[$]) : -1, 16'h02FF);
    chk("t2_done", done_cnt, 1);

    // odd-cycle trigger, page 2
    if (cyc % 2 == 0) idle_tick();
    clear_stats();
    tc = cyc;
    tick(16'h4014, 1'b0, 8'h02);
    wait_done(600);
    idle_n(4);
    chk("t3_rdy_low", rdy_low, 514);
    chk("t3_read_even", first_read_cyc % 2, 0);
    chk("t3_read_lat", first_read_cyc - tc, 3);

    // page 3 data pattern
    clear_stats();
    tick(16'h4014, 1'b0, 8'h03);
    wait_done(600);
    idle_n(6);
    chk("t4_writes", wq.size(), 256);
    for (int i = 0; i < wq.size(); i++)
      chk("t4_data", wq[i], i ^ 8'hA5);

    // reset during WRITE of byte 100
    clear_stats();
    tick(16'h4014, 1'b0, 8'h04);
    n = 0;
    while (wq.size() < 101 && n < 400) begin
      idle_tick();
      n++;
    end
    chk("t5_reach", wq.size(), 101);
    do_reset(1);
    chk("t5_rdy", rdy, 1);
    chk("t5_active", dma_active, 0);
    clear_stats();
    tick(16'h4014, 1'b0, 8'h05);
    n = 0;
    while (rq.size() == 0 && n < 10) begin
      idle_tick();
      n++;
    end
    chk("t5_first", rq.size() > 0 ? int'(rq[0]) : -1, 16'h0500);
    wait_done(600);
    idle_n(3);

    // negative and positive trigger table
    for (int i = 0; i < 6; i++) begin
      tick(vt[i].a, vt[i].rw, vt[i].d);
      chk("t6_vec", rdy, vt[i].exp_rdy);
      if (!vt[i].exp_rdy) wait_done(600);
      idle_n(2);
    end

    // triggers during a transfer are ignored
    clear_stats();
    tc = cyc;
    tick(16'h4014, 1'b0, 8'h06);
    idle_n(50);
    tick(16'h4014, 1'b0, 8'h09);
    idle_n(101);
    tick(16'h4014, 1'b0, 8'h0A);
    wait_done(600);
    e = (tc % 2 == 0) ? 513 : 514;
    chk("t6_rdy_low", rdy_low, e);
    chk("t6_reads", rq.size(), 256);
    chk("t6_last", rq.size() > 0 ? int'(rq[$]) : -1, 16'h06FF);

    // back-to-back: trigger in the done cycle
    tick(16'h4014, 1'b0, 8'h07);
    chk("t7_b2b_rdy", rdy, 0);
    chk("t7_b2b_act", dma_active, 1);
    wait_done(600);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      n = $urandom_range(0, 15);
      if (n == 0) tick(16'h4014, 1'b0, 8'($urandom));
      else if (n == 1) tick(16'h4014, 1'b1, 8'($urandom));
      else if (n == 2) tick(16'h4015, 1'b0, 8'($urandom));
      else idle_tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
